// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline: serialises loads/stores into byte requests over
// the shared memory port and stalls the pipeline until the access completes.
module mem_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rd_in,
  input  logic [31:0]           rd_val_in,
  input  logic [4:0]            rd_addr_in,
  input  logic [7:0]            inst_type_in,
  input  logic [ADDR_WIDTH-1:0] mem_addr_in,
  input  logic [31:0]           mem_val_in,
  input  logic                  mem_gnt_in,
  input  logic [7:0]            mem_din_in,
  output logic                  mem_req_out,
  output logic                  mem_wr_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [7:0]            mem_dout_out,
  output logic                  rd_out,
  output logic [31:0]           rd_val_out,
  output logic [4:0]            rd_addr_out,
  output logic                  stallreq_from_mem
);

  localparam logic [7:0] INST_LB  = 8'h01;
  localparam logic [7:0] INST_LH  = 8'h02;
  localparam logic [7:0] INST_LW  = 8'h03;
  localparam logic [7:0] INST_LBU = 8'h04;
  localparam logic [7:0] INST_LHU = 8'h05;
  localparam logic [7:0] INST_SB  = 8'h06;
  localparam logic [7:0] INST_SH  = 8'h07;
  localparam logic [7:0] INST_SW  = 8'h08;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  issue_cnt, recv_cnt, acc_size;
  logic        rd_pending;
  logic [31:0] result, load_ext;
  logic        is_load, is_store, is_mem;
  logic        req, grant, exit_busy;

  always_comb begin
    acc_size = 3'd0;
    is_load  = 1'b0;
    is_store = 1'b0;
    case (inst_type_in)
      INST_LB, INST_LBU: begin acc_size = 3'd1; is_load  = 1'b1; end
      INST_LH, INST_LHU: begin acc_size = 3'd2; is_load  = 1'b1; end
      INST_LW:           begin acc_size = 3'd4; is_load  = 1'b1; end
      INST_SB:           begin acc_size = 3'd1; is_store = 1'b1; end
      INST_SH:           begin acc_size = 3'd2; is_store = 1'b1; end
      INST_SW:           begin acc_size = 3'd4; is_store = 1'b1; end
      default:           ;
    endcase
    is_mem = is_load | is_store;
  end

  always_comb begin
    req   = (state == BUSY) && (issue_cnt < acc_size);
    grant = req && mem_gnt_in;
    // Stores finish on the last grant; loads finish when the last byte comes back.
    if (is_store)
      exit_busy = grant && (issue_cnt == 3'(acc_size - 3'd1));
    else
      exit_busy = rd_pending && (recv_cnt == 3'(acc_size - 3'd1));
  end

  always_comb begin
    case (inst_type_in)
      INST_LB:  load_ext = {{24{result[7]}}, result[7:0]};
      INST_LH:  load_ext = {{16{result[15]}}, result[15:0]};
      INST_LBU: load_ext = {24'd0, result[7:0]};
      INST_LHU: load_ext = {16'd0, result[15:0]};
      default:  load_ext = result;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      issue_cnt  <= '0;
      recv_cnt   <= '0;
      rd_pending <= 1'b0;
      result     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (is_mem) begin
          issue_cnt  <= '0;
          recv_cnt   <= '0;
          rd_pending <= 1'b0;
          result     <= '0;
        end
        BUSY: begin
          if (grant) issue_cnt <= issue_cnt + 3'd1;
          rd_pending <= grant && !is_store;
          if (rd_pending) begin
            result[{recv_cnt[1:0], 3'b000} +: 8] <= mem_din_in;
            recv_cnt <= recv_cnt + 3'd1;
          end
        end
        default: rd_pending <= 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nxt         = state;
    mem_req_out       = 1'b0;
    mem_wr_out        = 1'b0;
    mem_addr_out      = '0;
    mem_dout_out      = '0;
    rd_out            = 1'b0;
    rd_val_out        = '0;
    rd_addr_out       = '0;
    stallreq_from_mem = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem) begin
          stallreq_from_mem = 1'b1;
          state_nxt         = BUSY;
        end else begin
          rd_out      = rd_in;
          rd_val_out  = rd_val_in;
          rd_addr_out = rd_addr_in;
        end
      end
      BUSY: begin
        stallreq_from_mem = 1'b1;
        mem_req_out       = req;
        mem_wr_out        = is_store;
        mem_addr_out      = mem_addr_in + ADDR_WIDTH'(issue_cnt);
        mem_dout_out      = mem_val_in[{issue_cnt[1:0], 3'b000} +: 8];
        if (exit_busy) state_nxt = DONE;
      end
      DONE: begin
        rd_addr_out = rd_addr_in;
        if (is_load) begin
          rd_out     = rd_in;
          rd_val_out = load_ext;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline. Sits between the EX/MEM and MEM/WB pipeline registers.
- Consumes the EX result bundle and performs LB/LH/LW/LBU/LHU/SB/SH/SW over the shared byte-wide memory port, using a request/grant handshake with the memory controller arbiter.
- Raises stallreq_from_mem to the stall controller until the access completes. Passes non-memory instructions through unchanged.

Parameters:
ADDR_WIDTH, 32, width of data address and memory-port address

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous reset, active-high (`RstEnable = 1)
rd_in  input  1  write-back enable from EX/MEM
rd_val_in  input  `RegBus  EX result (ALU/link value)
rd_addr_in  input  `RegAddrBus  destination register
inst_type_in  input  `InstTypeBus  decoded instruction type
mem_addr_in  input  ADDR_WIDTH  effective load/store address
mem_val_in  input  `RegBus  store data (rs2)
mem_gnt_in  input  1  arbiter grant for the current byte request
mem_din_in  input  8  read byte, valid the cycle after a granted read
mem_req_out  output  1  byte request
mem_wr_out  output  1  1 = write, 0 = read (valid with mem_req_out)
mem_addr_out  output  ADDR_WIDTH  byte address
mem_dout_out  output  8  write byte
rd_out  output  1  write-back enable to MEM/WB
rd_val_out  output  `RegBus  write-back value
rd_addr_out  output  `RegAddrBus  write-back register
stallreq_from_mem  output  1  stall request to stall controller

Behaviour:
- Clock and reset: one clock, clk_in. rst_in is synchronous and active-high.
- Reset:
  - state = IDLE; issue_cnt, recv_cnt and result register cleared to 0.
  - All outputs 0: mem_req/wr/addr/dout, rd_out (`WriteDisable), rd_val_out (`ZeroWord), rd_addr_out (`NOPRegAdder), stallreq_from_mem.
  - Reset mid-access abandons the access. No further bytes are issued, and any read byte returning after reset is ignored.
- Access size N: 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW. No alignment check; byte k uses address mem_addr_in + k (little-endian).
- FSM states: IDLE, BUSY, DONE.
  - IDLE, non-memory type: combinational pass-through of rd_in / rd_val_in / rd_addr_in; stall 0; mem_req_out 0.
  - IDLE, memory type: stall 1 (combinational), then → BUSY next edge with issue_cnt = recv_cnt = 0.
  - BUSY: mem_req_out = (issue_cnt < N).
    - Outputs: mem_wr_out = store; mem_addr_out = mem_addr_in + issue_cnt; mem_dout_out = mem_val_in byte[issue_cnt].
    - A byte is issued on a cycle with mem_req_out && mem_gnt_in; issue_cnt increments. Without grant, request and address hold.
    - For loads, the byte returned the cycle after each granted read is written into result byte[recv_cnt]; recv_cnt increments.
    - Requests are pipelined: the next byte may be issued in the same cycle a previous byte returns.
    - Exit to DONE: for stores, on the edge where the last byte is granted; for loads, on the edge where byte N-1 is received.
    - stall = 1 throughout BUSY.
  - DONE: one cycle with stall 0, so the pipeline advances; → IDLE unconditionally.
    - rd_addr_out = rd_addr_in.
    - Loads: rd_out = rd_in; rd_val_out = result extended per type. LB sign-extends bit 7, LH bit 15, LBU/LHU zero-extend, LW as-is.
    - Stores: rd_out = `WriteDisable and rd_val_out = `ZeroWord.
- Upstream holds EX/MEM inputs stable while stalled. Inputs are sampled only at access start and during BUSY/DONE.
- Memory-port outputs are 0 outside BUSY.
- Latency with continuous grant, cycle 0 = instruction arrives:
  - LB: issue c1, data c2, DONE c3.
  - LW: issue c1–c4, data c2–c5, DONE c6.
  - SB: DONE c2. SW: DONE c5.
- Grant gaps extend latency one cycle per ungranted request cycle.
- Address wrap: mem_addr_in + k wraps modulo 2^ADDR_WIDTH.

Test Plan:
- Reset then ADDI pass-through: rd_in=1, rd_val_in=0x1234, rd_addr_in=5 → same values on outputs the same cycle; stall 0; mem_req_out never high.
- LW @0x100, grant always, memory returns 0x78,0x56,0x34,0x12 → addresses 0x100–0x103 on c1–c4, wr=0; stall high c0–c5; DONE c6 with rd_val_out=0x12345678.
- LB @0x200 returning 0x80 → rd_val_out=0xFFFFFF80. Same access as LBU → 0x00000080. LH returning 0x01,0xFF → 0xFFFFFF01.
- SH @0x300, mem_val_in=0xAABBCCDD, grant withheld on c1 → c1 holds addr 0x300; bytes 0xDD@0x300 (c2), 0xCC@0x301 (c3); DONE c4 with rd_out=0.
- SW @0xFFFFFFFE → byte addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 (wrap).
- LW with rst_in asserted at c3 → next cycle all outputs 0, state IDLE; a late mem_din_in byte does not change rd_val_out. A following ADDI passes through normally.
